// File: rtl/lipsi_uart_loader.sv
// Serial program loader for Lipsi: receives a framed 8N1 image, writes it into the
// 256x8 instruction memory and releases the processor only after a checksum match.
module lipsi_uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_hold,
   output logic       busy,
   output logic       load_done,
   output logic       load_err
);

   localparam int unsigned    CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [1:0] {L_SYNC, L_LEN, L_DATA, L_CSUM} ld_state_e;

   // receiver state
   logic          sync1_q, sync2_q, rx_prev_q;
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_ferr_q, rx_ferr_d;

   // loader state
   ld_state_e     ld_state_q, ld_state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    count_q, count_d;
   logic [7:0]    csum_q, csum_d;
   logic          mem_we_q, mem_we_d;
   logic [7:0]    mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic          cpu_hold_q, cpu_hold_d;
   logic          busy_q, busy_d;
   logic          load_done_q, load_done_d;
   logic          load_err_q, load_err_d;

   logic          rx_sync;
   assign rx_sync = sync2_q;

   // Start-bit detection is edge based, so a line stuck low after a framing
   // error cannot retrigger the receiver until it has returned high.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a latch behind.
      rx_state_d = rx_state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync) begin
               rx_state_d = RX_START;
               clk_cnt_d  = HALF;
            end
         end
         RX_START: begin
            if (clk_cnt_q == '0) begin
               if (!rx_sync) begin
                  rx_state_d = RX_DATA;
                  clk_cnt_d  = FULL;
                  bit_idx_d  = 3'd0;
               end else begin
                  rx_state_d = RX_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end
         end
         RX_DATA: begin
            if (clk_cnt_q == '0) begin
               shift_d   = {rx_sync, shift_q[7:1]};
               clk_cnt_d = FULL;
               if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
               else                   bit_idx_d  = bit_idx_q + 3'd1;
            end else begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end
         end
         RX_STOP: begin
            if (clk_cnt_q == '0) begin
               if (rx_sync) begin
                  rx_valid_d = 1'b1;
                  rx_byte_d  = shift_q;
               end else begin
                  rx_ferr_d  = 1'b1;
               end
               rx_state_d = RX_IDLE;
            end else begin
               clk_cnt_d = clk_cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      ld_state_d  = ld_state_q;
      len_d       = len_q;
      count_d     = count_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      busy_d      = busy_q;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      if (rx_ferr_q && ld_state_q != L_SYNC) begin
         load_err_d = 1'b1;
         busy_d     = 1'b0;
         ld_state_d = L_SYNC;
      end else if (rx_valid_q) begin
         unique case (ld_state_q)
            L_SYNC: begin
               if (rx_byte_q == SYNC_BYTE) begin
                  ld_state_d = L_LEN;
                  busy_d     = 1'b1;
                  cpu_hold_d = 1'b1;
               end
            end
            L_LEN: begin
               len_d      = rx_byte_q;
               count_d    = 8'd0;
               csum_d     = 8'd0;
               ld_state_d = L_DATA;
            end
            L_DATA: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = count_q;
               mem_wdata_d = rx_byte_q;
               csum_d      = csum_q + rx_byte_q;
               count_d     = count_q + 8'd1;
               // 8-bit wrap makes a length of 0 complete after 256 bytes
               if (count_d == len_q) ld_state_d = L_CSUM;
            end
            L_CSUM: begin
               if (rx_byte_q == csum_q) begin
                  load_done_d = 1'b1;
                  cpu_hold_d  = 1'b0;
               end else begin
                  load_err_d  = 1'b1;
               end
               busy_d     = 1'b0;
               ld_state_d = L_SYNC;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'd0;
         rx_byte_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         rx_ferr_q   <= 1'b0;
         ld_state_q  <= L_SYNC;
         len_q       <= 8'd0;
         count_q     <= 8'd0;
         csum_q      <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 8'd0;
         mem_wdata_q <= 8'd0;
         cpu_hold_q  <= 1'b0;
         busy_q      <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         sync1_q     <= rxd;
         sync2_q     <= sync1_q;
         rx_prev_q   <= rx_sync;
         rx_state_q  <= rx_state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_ferr_q   <= rx_ferr_d;
         ld_state_q  <= ld_state_d;
         len_q       <= len_d;
         count_q     <= count_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign busy      = busy_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_lipsi_uart_loader.sv
// Bench for lipsi_uart_loader: directed frames plus random frames, checked against
// a frame-level model that parses the byte stream into expected writes and results.
module tb_lipsi_uart_loader;

   localparam int CPB = 16;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       busy;
   logic       load_done;
   logic       load_err;

   int n_asserts = 0;
   int n_fail    = 0;

   logic [15:0] obs_w[$];
   logic [15:0] exp_w[$];
   int          done_seen, err_seen, dbl_we;
   int          exp_done, exp_err;
   logic        exp_hold;
   logic        we_prev;

   lipsi_uart_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .reset    (reset),
      .rxd      (rxd),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .load_done(load_done),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we) obs_w.push_back({mem_addr, mem_wdata});
         if (mem_we && we_prev) dbl_we++;
         if (load_done) done_seen++;
         if (load_err) err_seen++;
         we_prev = mem_we;
      end else begin
         we_prev = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_log();
      obs_w.delete();
      done_seen = 0;
      err_seen  = 0;
      dbl_we    = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      if (!stop_bit) repeat (CPB) @(negedge clk);
   endtask

   // Frame-level reference: scan for the marker, take the length (0 = 256),
   // the payload lands at consecutive addresses, then the checksum decides.
   task automatic model_stream(input byte_q_t s);
      int i, n;
      logic [7:0] sum;
      exp_w.delete();
      exp_done = 0;
      exp_err  = 0;
      i = 0;
      while (i < s.size()) begin
         if (s[i] != 8'hA5) begin
            i++;
         end else begin
            n   = (s[i+1] == 8'd0) ? 256 : int'(s[i+1]);
            sum = 8'd0;
            for (int k = 0; k < n; k++) begin
               exp_w.push_back({8'(k), s[i+2+k]});
               sum = sum + s[i+2+k];
            end
            if (s[i+2+n] == sum) begin
               exp_done++;
               exp_hold = 1'b0;
            end else begin
               exp_err++;
               exp_hold = 1'b1;
            end
            i = i + n + 3;
         end
      end
   endtask

   task automatic compare(input byte_q_t s, input string tag);
      model_stream(s);
      check({tag, "_nwr"}, obs_w.size(), exp_w.size());
      for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++)
         check({tag, "_wr"}, obs_w[k], exp_w[k]);
      check({tag, "_done"}, done_seen, exp_done);
      check({tag, "_err"}, err_seen, exp_err);
      check({tag, "_we1"}, dbl_we, 0);
      check({tag, "_hold"}, cpu_hold, exp_hold);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic run_stream(input byte_q_t s, input string tag);
      start_log();
      foreach (s[i]) send_byte(s[i], 1'b1);
      repeat (4) @(negedge clk);
      compare(s, tag);
   endtask

   task automatic random_frame(input logic good, output byte_q_t s);
      int n, pre;
      logic [7:0] b, sum;
      s   = {};
      pre = $urandom_range(2, 0);
      repeat (pre) begin
         b = 8'($urandom_range(255, 0));
         if (b == 8'hA5) b = 8'h5A;
         s.push_back(b);
      end
      s.push_back(8'hA5);
      n = $urandom_range(6, 1);
      s.push_back(8'(n));
      sum = 8'd0;
      for (int k = 0; k < n; k++) begin
         b = 8'($urandom_range(255, 0));
         s.push_back(b);
         sum = sum + b;
      end
      s.push_back(good ? sum : sum + 8'($urandom_range(255, 1)));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, mem_we, 1'b0);
      check({tag, "_addr"}, mem_addr, 8'd0);
      check({tag, "_wdata"}, mem_wdata, 8'd0);
      check({tag, "_hold"}, cpu_hold, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, load_done, 1'b0);
      check({tag, "_err"}, load_err, 1'b0);
   endtask

   initial begin
      byte_q_t s;
      logic [7:0] f1[5];
      f1 = '{8'hA5, 8'h03, 8'hC7, 8'h00, 8'h81};

      // reset
      rxd      = 1'b1;
      reset    = 1'b1;
      exp_hold = 1'b0;
      start_log();
      #1;
      check_reset_outputs("rst");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // basic frame with per-byte latency and hold/busy during the frame
      start_log();
      send_byte(f1[0], 1'b1);
      send_byte(f1[1], 1'b1);
      check("f1_hold_mid", cpu_hold, 1'b1);
      check("f1_busy_mid", busy, 1'b1);
      for (int k = 2; k < 5; k++) begin
         send_byte(f1[k], 1'b1);
         check("f1_wr_latency", obs_w.size(), k - 1);
      end
      send_byte(8'h48, 1'b1);
      check("f1_done_in_stop", done_seen, 1);
      repeat (4) @(negedge clk);
      compare('{8'hA5, 8'h03, 8'hC7, 8'h00, 8'h81, 8'h48}, "f1");

      // bad checksum keeps the processor held, a good frame releases it
      run_stream('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31}, "badcs");
      random_frame(1'b1, s);
      run_stream(s, "recover");

      // leading garbage ignored
      run_stream('{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'hFF, 8'hFF}, "garbage");

      // full 256-byte image
      s = {8'hA5, 8'h00};
      for (int k = 0; k < 256; k++) s.push_back(8'(k));
      s.push_back(8'h80);
      run_stream(s, "full256");

      // framing error mid-frame
      start_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h04, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h5A, 1'b0);
      repeat (4) @(negedge clk);
      check("ferr_nwr", obs_w.size(), 1);
      if (obs_w.size() > 0) check("ferr_wr0", obs_w[0], 16'h0001);
      check("ferr_err", err_seen, 1);
      check("ferr_done", done_seen, 0);
      check("ferr_hold", cpu_hold, 1'b1);
      check("ferr_busy", busy, 1'b0);
      exp_hold = 1'b1;

      // short glitch while waiting for the length must not become a byte
      start_log();
      send_byte(8'hA5, 1'b1);
      rxd = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      send_byte(8'h01, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'hFF, 1'b1);
      repeat (4) @(negedge clk);
      compare('{8'hA5, 8'h01, 8'hFF, 8'hFF}, "glitch");

      // reset during the start bit of the second data byte
      start_log();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h04, 1'b1);
      send_byte(8'h11, 1'b1);
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_nwr", obs_w.size(), 1);
      check("midrst_done", done_seen, 0);
      check("midrst_err", err_seen, 0);
      exp_hold = 1'b0;
      random_frame(1'b1, s);
      run_stream(s, "postrst");

      // random frames, mixed good and bad checksums
      for (int r = 0; r < 6; r++) begin
         random_frame(logic'($urandom_range(1, 0)), s);
         run_stream(s, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
